// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arb_pkg
// Purpose  : Shared definitions for the generic bus arbiter: requester count
//            and the arbitration FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

  localparam int NUM_REQ = 2;

  // IDLE: no owner; GNT0/GNT1: requester 0/1 owns the slave port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Two-way round-robin selector. Picks the single active requester,
//            or on a tie the requester that did not own the bus last.
// Ports    : req        - request vector, one bit per requester
//            last_owner - index of the most recent completed owner
//            valid      - at least one requester is active
//            pick       - index of the selected requester
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_owner,
  output logic               valid,
  output logic               pick
);

  always_comb begin
    valid = |req;
    pick  = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_owner;
      default: pick = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/generic_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : generic_bus_arbiter
// Purpose  : Arbitrates two bus requesters (0 = core, 1 = debug/test) onto a
//            single slave port. Round-robin or fixed priority (0 highest).
//            A grant is held until the owner completes or withdraws.
// Ports    : clk, rst                  - clock, async active-high reset
//            m_addr/m_ren/m_wen/m_wdata/m_byte_en - per-requester request
//            m_rdata/m_busy            - per-requester response
//            s_addr/s_ren/s_wen/s_wdata/s_byte_en - slave request fields
//            s_rdata/s_busy            - slave response
//            grant                     - one-hot current owner, 00 when idle
// Revision : 1.0 - initial release
// ============================================================================
module generic_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int RR_EN  = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]     m_addr,
  input  logic [NUM_REQ-1:0]                 m_ren,
  input  logic [NUM_REQ-1:0]                 m_wen,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     m_wdata,
  input  logic [NUM_REQ-1:0][DATA_W/8-1:0]   m_byte_en,
  output logic [NUM_REQ-1:0][DATA_W-1:0]     m_rdata,
  output logic [NUM_REQ-1:0]                 m_busy,
  output logic [ADDR_W-1:0]                  s_addr,
  output logic [DATA_W-1:0]                  s_wdata,
  output logic [DATA_W/8-1:0]                s_byte_en,
  output logic                               s_ren,
  output logic                               s_wen,
  input  logic [DATA_W-1:0]                  s_rdata,
  input  logic                               s_busy,
  output logic [NUM_REQ-1:0]                 grant
);

  arb_state_t         r_state;
  logic               r_last_owner;
  logic [NUM_REQ-1:0] r_grant;

  logic [NUM_REQ-1:0] w_req;
  logic               w_pick_valid;
  logic               w_rr_pick;
  logic               w_idle_pick;
  logic               w_owned;
  logic               w_sel;

  assign w_req = m_ren | m_wen;

  rr_pick u_rr_pick (
    .req        (w_req),
    .last_owner (r_last_owner),
    .valid      (w_pick_valid),
    .pick       (w_rr_pick)
  );

  // Fixed priority: requester 1 is chosen only when requester 0 is quiet.
  assign w_idle_pick = (RR_EN != 0) ? w_rr_pick : ~w_req[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;   // requester 0 wins the first tie
      r_grant      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_state <= w_idle_pick ? GNT1 : GNT0;
            r_grant <= w_idle_pick ? 2'b10 : 2'b01;
          end
        end
        GNT0: begin
          if (!w_req[0]) begin
            // Withdrawn before completion: release without recording owner.
            r_state <= IDLE;
            r_grant <= '0;
          end else if (!s_busy) begin
            r_last_owner <= 1'b0;
            // Fixed priority always re-arbitrates through IDLE from GNT0 so a
            // persistent requester 0 keeps winning.
            if ((RR_EN != 0) && w_req[1]) begin
              r_state <= GNT1;
              r_grant <= 2'b10;
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
            end
          end
        end
        GNT1: begin
          if (!w_req[1]) begin
            r_state <= IDLE;
            r_grant <= '0;
          end else if (!s_busy) begin
            r_last_owner <= 1'b1;
            // Both modes hand straight over to a waiting requester 0.
            if (w_req[0]) begin
              r_state <= GNT0;
              r_grant <= 2'b01;
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant   = r_grant;
  assign w_owned = (r_state == GNT0) || (r_state == GNT1);
  assign w_sel   = (r_state == GNT1);

  // Slave-side mux is driven purely from the state register so a reset
  // removes the strobes immediately.
  always_comb begin
    s_addr    = '0;
    s_wdata   = '0;
    s_byte_en = '0;
    s_ren     = 1'b0;
    s_wen     = 1'b0;
    m_rdata   = '0;
    m_busy    = '1;
    if (w_owned) begin
      s_addr         = m_addr[w_sel];
      s_wdata        = m_wdata[w_sel];
      s_byte_en      = m_byte_en[w_sel];
      s_ren          = m_ren[w_sel];
      s_wen          = m_wen[w_sel];
      m_rdata[w_sel] = s_rdata;
      m_busy[w_sel]  = s_busy;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_generic_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_generic_bus_arbiter
// Purpose  : Directed self-checking bench. One round-robin and one fixed
//            priority arbiter share the same stimulus; each scenario task
//            checks the instance(s) it targets against hand-derived values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_generic_bus_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0][31:0]  m_addr;
  logic [1:0]        m_ren;
  logic [1:0]        m_wen;
  logic [1:0][31:0]  m_wdata;
  logic [1:0][3:0]   m_byte_en;
  logic [31:0]       s_rdata;
  logic              s_busy;

  logic [1:0][31:0]  rr_m_rdata, fp_m_rdata;
  logic [1:0]        rr_m_busy, fp_m_busy;
  logic [31:0]       rr_s_addr, fp_s_addr, rr_s_wdata, fp_s_wdata;
  logic [3:0]        rr_s_byte_en, fp_s_byte_en;
  logic              rr_s_ren, fp_s_ren, rr_s_wen, fp_s_wen;
  logic [1:0]        rr_grant, fp_grant;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  generic_bus_arbiter #(.RR_EN(1), .ADDR_W(32), .DATA_W(32)) u_rr (
    .clk(clk), .rst(rst), .m_addr(m_addr), .m_ren(m_ren), .m_wen(m_wen),
    .m_wdata(m_wdata), .m_byte_en(m_byte_en), .m_rdata(rr_m_rdata),
    .m_busy(rr_m_busy), .s_addr(rr_s_addr), .s_wdata(rr_s_wdata),
    .s_byte_en(rr_s_byte_en), .s_ren(rr_s_ren), .s_wen(rr_s_wen),
    .s_rdata(s_rdata), .s_busy(s_busy), .grant(rr_grant)
  );

  generic_bus_arbiter #(.RR_EN(0), .ADDR_W(32), .DATA_W(32)) u_fp (
    .clk(clk), .rst(rst), .m_addr(m_addr), .m_ren(m_ren), .m_wen(m_wen),
    .m_wdata(m_wdata), .m_byte_en(m_byte_en), .m_rdata(fp_m_rdata),
    .m_busy(fp_m_busy), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
    .s_byte_en(fp_s_byte_en), .s_ren(fp_s_ren), .s_wen(fp_s_wen),
    .s_rdata(s_rdata), .s_busy(s_busy), .grant(fp_grant)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_addr = '0; m_ren = '0; m_wen = '0; m_wdata = '0; m_byte_en = '0;
    s_rdata = '0; s_busy = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    m_ren = 2'b11;   // requests during reset must not produce strobes
    #1;
    n_cmp++; if (rr_grant !== 2'b00) begin n_bad++; $display("FAIL reset_rr_grant: got %b want 00", rr_grant); end
    n_cmp++; if (fp_grant !== 2'b00) begin n_bad++; $display("FAIL reset_fp_grant: got %b want 00", fp_grant); end
    step();
    n_cmp++; if ({rr_s_ren, rr_s_wen, fp_s_ren, fp_s_wen} !== 4'b0000) begin n_bad++; $display("FAIL reset_strobes: got %b want 0000", {rr_s_ren, rr_s_wen, fp_s_ren, fp_s_wen}); end
    n_cmp++; if (rr_m_busy !== 2'b11) begin n_bad++; $display("FAIL reset_m_busy: got %b want 11", rr_m_busy); end
    n_cmp++; if (rr_s_addr !== 32'h0) begin n_bad++; $display("FAIL reset_s_addr: got %h want 0", rr_s_addr); end
    n_cmp++; if (rr_grant !== 2'b00) begin n_bad++; $display("FAIL reset_hold_grant: got %b want 00", rr_grant); end
    do_reset();
  endtask

  task automatic test_single();
    int low_cnt = 0;
    do_reset();
    m_ren[0] = 1'b1; m_addr[0] = 32'h100; m_byte_en[0] = 4'hF;
    s_busy = 1'b1; s_rdata = 32'hCAFE_0001;
    #1;
    n_cmp++; if (rr_grant !== 2'b00) begin n_bad++; $display("FAIL single_latency: got %b want 00", rr_grant); end
    n_cmp++; if (rr_s_ren !== 1'b0) begin n_bad++; $display("FAIL single_idle_ren: got %b want 0", rr_s_ren); end
    step();
    if (rr_m_busy[0] === 1'b0) low_cnt++;
    n_cmp++; if (rr_grant !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b want 01", rr_grant); end
    n_cmp++; if (fp_grant !== 2'b01) begin n_bad++; $display("FAIL single_fp_grant: got %b want 01", fp_grant); end
    n_cmp++; if ({rr_s_ren, rr_s_addr, rr_s_byte_en} !== {1'b1, 32'h100, 4'hF}) begin n_bad++; $display("FAIL single_slave_fields: got %b %h %h want 1 00000100 f", rr_s_ren, rr_s_addr, rr_s_byte_en); end
    step();
    if (rr_m_busy[0] === 1'b0) low_cnt++;
    n_cmp++; if (rr_grant !== 2'b01) begin n_bad++; $display("FAIL single_hold: got %b want 01", rr_grant); end
    s_busy = 1'b0;
    #1;
    if (rr_m_busy[0] === 1'b0) low_cnt++;
    n_cmp++; if (rr_m_busy !== 2'b10) begin n_bad++; $display("FAIL single_busy_low: got %b want 10", rr_m_busy); end
    n_cmp++; if (rr_m_rdata[0] !== 32'hCAFE_0001) begin n_bad++; $display("FAIL single_rdata0: got %h want cafe0001", rr_m_rdata[0]); end
    n_cmp++; if (rr_m_rdata[1] !== 32'h0) begin n_bad++; $display("FAIL single_rdata1: got %h want 0", rr_m_rdata[1]); end
    step();
    // Completion returns to IDLE even though requester 0 still holds.
    if (rr_m_busy[0] === 1'b0) low_cnt++;
    n_cmp++; if ({rr_grant, fp_grant} !== 4'b0000) begin n_bad++; $display("FAIL single_to_idle: got %b want 0000", {rr_grant, fp_grant}); end
    n_cmp++; if (rr_s_ren !== 1'b0) begin n_bad++; $display("FAIL single_idle_strobe: got %b want 0", rr_s_ren); end
    n_cmp++; if (low_cnt !== 1) begin n_bad++; $display("FAIL single_busy_once: got %0d want 1", low_cnt); end
    m_ren = '0; s_busy = 1'b1;
    step();
  endtask

  task automatic test_rr_alternate();
    logic [1:0] exp_rr [6];
    logic [1:0] exp_fp [6];
    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    exp_fp = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    do_reset();
    m_ren = 2'b11; m_addr[0] = 32'h200; m_addr[1] = 32'h300; s_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if (rr_grant !== exp_rr[i]) begin n_bad++; $display("FAIL alt_rr_grant[%0d]: got %b want %b", i, rr_grant, exp_rr[i]); end
      n_cmp++; if (rr_s_addr !== ((exp_rr[i] == 2'b01) ? 32'h200 : 32'h300)) begin n_bad++; $display("FAIL alt_rr_addr[%0d]: got %h", i, rr_s_addr); end
      n_cmp++; if (fp_grant !== exp_fp[i]) begin n_bad++; $display("FAIL alt_fp_grant[%0d]: got %b want %b", i, fp_grant, exp_fp[i]); end
      n_cmp++; if (fp_m_busy[1] !== 1'b1) begin n_bad++; $display("FAIL alt_fp_busy1[%0d]: got %b want 1", i, fp_m_busy[1]); end
    end
    m_ren[0] = 1'b0;
    step();
    n_cmp++; if ({rr_grant, fp_grant} !== 4'b0010) begin n_bad++; $display("FAIL fp_req1_after_drop: got %b want 0010", {rr_grant, fp_grant}); end
    step();
    n_cmp++; if ({rr_grant, fp_grant} !== 4'b1000) begin n_bad++; $display("FAIL fp_req1_done: got %b want 1000", {rr_grant, fp_grant}); end
    m_ren = '0;
    step();
    n_cmp++; if ({rr_grant, fp_grant} !== 4'b0000) begin n_bad++; $display("FAIL alt_final_idle: got %b want 0000", {rr_grant, fp_grant}); end
    s_busy = 1'b1;
  endtask

  task automatic test_no_preempt();
    do_reset();
    m_wen[0] = 1'b1; m_addr[0] = 32'h400; m_wdata[0] = 32'hDEAD_BEEF; m_byte_en[0] = 4'h3;
    s_busy = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      n_cmp++; if ({rr_grant, fp_grant} !== 4'b0101) begin n_bad++; $display("FAIL nopre_grant[%0d]: got %b want 0101", c, {rr_grant, fp_grant}); end
      n_cmp++; if ({rr_m_busy[1], fp_m_busy[1]} !== 2'b11) begin n_bad++; $display("FAIL nopre_busy1[%0d]: got %b want 11", c, {rr_m_busy[1], fp_m_busy[1]}); end
      if (c == 1) begin
        n_cmp++; if ({rr_s_wen, rr_s_wdata, rr_s_byte_en} !== {1'b1, 32'hDEAD_BEEF, 4'h3}) begin n_bad++; $display("FAIL nopre_wfields: got %b %h %h want 1 deadbeef 3", rr_s_wen, rr_s_wdata, rr_s_byte_en); end
      end
      if (c == 2) begin
        m_ren[1] = 1'b1; m_addr[1] = 32'h500;
      end
    end
    s_busy = 1'b0;
    step();
    n_cmp++; if ({rr_grant, fp_grant} !== 4'b1000) begin n_bad++; $display("FAIL nopre_handover: got %b want 1000", {rr_grant, fp_grant}); end
    n_cmp++; if ({rr_s_ren, rr_s_wen, rr_s_addr} !== {2'b10, 32'h500}) begin n_bad++; $display("FAIL nopre_rr_fields: got %b%b %h want 10 00000500", rr_s_ren, rr_s_wen, rr_s_addr); end
    m_wen[0] = 1'b0;
    step();
    n_cmp++; if ({rr_grant, fp_grant} !== 4'b0010) begin n_bad++; $display("FAIL nopre_after: got %b want 0010", {rr_grant, fp_grant}); end
    m_ren[1] = 1'b0;
    step();
    n_cmp++; if ({rr_grant, fp_grant} !== 4'b0000) begin n_bad++; $display("FAIL nopre_idle: got %b want 0000", {rr_grant, fp_grant}); end
    s_busy = 1'b1;
  endtask

  task automatic test_abort_reset();
    do_reset();
    // Complete one read on requester 0 so last_owner becomes 0.
    m_ren[0] = 1'b1; s_busy = 1'b0;
    step();
    step();
    m_ren[0] = 1'b0;
    n_cmp++; if ({rr_grant, fp_grant} !== 4'b0000) begin n_bad++; $display("FAIL abort_setup: got %b want 0000", {rr_grant, fp_grant}); end
    m_wen[1] = 1'b1; m_addr[1] = 32'h600; s_busy = 1'b1;
    step();
    n_cmp++; if ({rr_grant, fp_grant, rr_s_wen} !== 5'b10101) begin n_bad++; $display("FAIL abort_gnt1: got %b want 10101", {rr_grant, fp_grant, rr_s_wen}); end
    m_ren[0] = 1'b1;
    step();
    n_cmp++; if ({rr_grant, fp_grant} !== 4'b1010) begin n_bad++; $display("FAIL abort_no_preempt: got %b want 1010", {rr_grant, fp_grant}); end
    n_cmp++; if (fp_m_busy[0] !== 1'b1) begin n_bad++; $display("FAIL abort_busy0: got %b want 1", fp_m_busy[0]); end
    m_wen[1] = 1'b0;
    step();
    n_cmp++; if ({rr_grant, fp_grant} !== 4'b0000) begin n_bad++; $display("FAIL abort_idle: got %b want 0000", {rr_grant, fp_grant}); end
    // Tie: round-robin still sees last_owner = 0 and favours requester 1.
    m_wen[1] = 1'b1;
    step();
    n_cmp++; if ({rr_grant, fp_grant} !== 4'b1001) begin n_bad++; $display("FAIL abort_last_owner: got %b want 1001", {rr_grant, fp_grant}); end
    n_cmp++; if ({rr_s_wen, fp_s_ren} !== 2'b11) begin n_bad++; $display("FAIL midrst_pre: got %b want 11", {rr_s_wen, fp_s_ren}); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({rr_s_wen, fp_s_ren} !== 2'b00) begin n_bad++; $display("FAIL midrst_strobes: got %b want 00", {rr_s_wen, fp_s_ren}); end
    n_cmp++; if ({rr_grant, fp_grant} !== 4'b0000) begin n_bad++; $display("FAIL midrst_grant: got %b want 0000", {rr_grant, fp_grant}); end
    #1;
    rst = 1'b0;
    step();
    n_cmp++; if ({rr_grant, fp_grant} !== 4'b0101) begin n_bad++; $display("FAIL midrst_first_tie: got %b want 0101", {rr_grant, fp_grant}); end
    clear_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_alternate();
    test_no_preempt();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/generic_bus_arbiter.md
GENERIC_BUS_ARBITER -- requirements
Module: generic_bus_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin between requesters, 0 = fixed priority with requester 0 highest.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width; byte_en width is DATA_W/8.
REQ-004 CLK  in  1  sole clock; all state changes on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 m_addr  in  2xADDR_W  per-requester address; index 0 = core, index 1 = debug/test port.
REQ-007 m_ren  in  2  per-requester read request.
REQ-008 m_wen  in  2  per-requester write request.
REQ-009 m_wdata  in  2xDATA_W  per-requester write data.
REQ-010 m_byte_en  in  2x(DATA_W/8)  per-requester byte enables.
REQ-011 m_rdata  out  2xDATA_W  read data returned to each requester.
REQ-012 m_busy  out  2  per-requester busy; low means that requester's transaction completed this cycle.
REQ-013 s_addr, s_wdata, s_byte_en  out  ADDR_W / DATA_W / DATA_W/8  slave-side request fields.
REQ-014 s_ren, s_wen  out  1 each  slave-side read and write strobes.
REQ-015 s_rdata  in  DATA_W  slave read data.
REQ-016 s_busy  in  1  slave busy, with generic_bus_if semantics.
REQ-017 grant  out  2  one-hot current owner; 00 when idle.

Function
REQ-018 A requester's request is m_ren[i] | m_wen[i].
REQ-019 FSM states: IDLE, GNT0, GNT1; the state register drives all slave-side muxing.
REQ-020 IDLE with one requester active: go to that requester's GNT state next cycle (1-cycle arbitration latency).
REQ-021 IDLE with both active, RR_EN=1: grant the requester not equal to last_owner; RR_EN=0: grant requester 0.
REQ-022 In GNTi: s_* follows m_*[i] combinationally; m_rdata[i] = s_rdata; m_busy[i] = s_busy.
REQ-023 Non-granted requester j: m_busy[j] = 1 whenever it requests; m_rdata[j] = 0.
REQ-024 In IDLE: s_ren = s_wen = 0, s_addr = s_wdata = 0, s_byte_en = 0, all m_busy = 1.
REQ-025 Completion: in GNTi, request[i] = 1 and s_busy = 0; last_owner <= i on that edge.
REQ-026 On completion with the other requester active (RR_EN=1), or requester 0 active while in GNT1 (RR_EN=0): go directly to the other GNT state with no IDLE bubble.
REQ-027 On completion otherwise: go to IDLE, even if requester i holds its request (fairness re-arbitration).
REQ-028 Abort: in GNTi, request[i] drops before completion -> IDLE next cycle; last_owner unchanged.
REQ-029 A grant is never preempted mid-transaction, including by a higher-priority requester.
REQ-030 m_ren and m_wen both high on the granted requester: pass both through unmodified; the slave defines the behaviour.

Reset
REQ-031 RST high, asynchronously: state = IDLE, last_owner = 1 (so requester 0 wins the first tie), grant = 00, s_ren = s_wen = 0.
REQ-032 RST asserted mid-transaction: slave strobes drop in the same cycle, with no completion recorded.

Structure
REQ-033 The FSM state enum arb_state_t and the requester count constant NUM_REQ = 2 live in a shared package, bus_arb_pkg.
REQ-034 One sub-module: rr_pick (2-input round-robin select from the request vector and last_owner), reused for N-way extension.

Verification
REQ-035 Single requester: m_ren[0] = 1, addr 0x100, s_busy low after 2 cycles -> grant = 01 one cycle later; m_busy[0] low exactly once; m_rdata[0] = s_rdata; then IDLE.
REQ-036 Simultaneous requests, RR_EN=1, both held for 3 transactions each -> grants alternate 01,10,01,10,... with no IDLE cycle between.
REQ-037 Simultaneous requests, RR_EN=0, both held -> requester 0 is granted after each completion; requester 1 is granted only once requester 0 deasserts.
REQ-038 Requester 0 granted with s_busy held high for 5 cycles; requester 1 requests at cycle 2 -> no preemption; m_busy[1] stays 1; grant switches to 10 after completion.
REQ-039 Abort, then reset mid-transaction: m_wen[1] dropped while s_busy = 1 -> IDLE next cycle, last_owner unchanged; RST pulsed during a GNT -> s_wen = 0 in the same cycle, grant = 00, and the first tie after reset goes to requester 0.
